mcycle_scheduler: RTL and testbench
===================================

MCYCLE_SCHEDULER -- requirements
Module: mcycle_scheduler

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have parameter TIMEOUT, default 64, maximum WAIT cycles before error; legal range 2..1024.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req_valid  input  1  execute stage requests a multi-cycle operation.
REQ-006 SHALL have port req_sel  input  2  target unit: 0 divider, 1 carry-less multiplier, 2 FPU, 3 reserved.
REQ-007 SHALL have port clear  input  1  pipeline flush; aborts any operation.
REQ-008 SHALL have port unit_en  output  3  one-hot start pulse, bit i = unit i.
REQ-009 SHALL have port unit_ready  input  3  per-unit result-valid.
REQ-010 SHALL have port unit_result  input  3*XLEN  per-unit result, unit i in bits [i*XLEN +: XLEN].
REQ-011 SHALL have port resp_valid  output  1  result held for the execute stage.
REQ-012 SHALL have port resp_data  output  XLEN  captured result.
REQ-013 SHALL have port resp_error  output  1  reserved selector or timeout; qualified by resp_valid.
REQ-014 SHALL have port resp_ack  input  1  execute stage consumes the response.
REQ-015 SHALL have port stall  output  1  execute stage must hold.
REQ-016 SHALL have port busy  output  1  state != IDLE.

Function
REQ-017 SHALL implement states IDLE, ISSUE, WAIT, DONE.
REQ-018 IDLE: req_valid=1 and clear=0 SHALL latch req_sel and go to ISSUE; req_sel=3 SHALL instead go to DONE with error=1, data=0.
REQ-019 ISSUE: unit_en SHALL equal one-hot of the latched selector for exactly this one cycle, then go to WAIT with the timeout counter at 0.
REQ-020 unit_en SHALL be 0 in every state other than ISSUE and SHALL be 0 in ISSUE when clear=1.
REQ-021 WAIT: only unit_ready of the latched unit SHALL be sampled; when it is 1, its unit_result is captured and the FSM goes to DONE with error=0.
REQ-022 WAIT: the counter SHALL increment each cycle without ready; when the counter equals TIMEOUT-1 and ready is 0, the FSM SHALL go to DONE with error=1, data=0.
REQ-023 Ready and timeout in the same cycle SHALL resolve as ready (error=0).
REQ-024 DONE: resp_valid=1 and resp_data/resp_error SHALL stay stable until resp_ack=1; then the FSM goes to IDLE.
REQ-025 resp_ack outside DONE SHALL be ignored; a new request SHALL be accepted only in IDLE, so minimum back-to-back spacing is 4 cycles.
REQ-026 stall SHALL be combinational: (IDLE and req_valid and not clear) or ISSUE or WAIT.
REQ-027 clear=1 in any state SHALL force IDLE on the next edge, discard the captured result, and leave resp_valid=0 from that edge; clear has priority over ack, ready and timeout.
REQ-028 Minimum latency: request at edge N, unit_en high in cycle N+1, ready earliest sampled in cycle N+2, resp_valid high from N+3.

Reset
REQ-029 rst=1 SHALL immediately force state IDLE, counter 0, latched selector 0, resp_data 0, resp_error 0.
REQ-030 During reset, unit_en SHALL be 0, and resp_valid, stall and busy SHALL be 0 irrespective of clk.
REQ-031 Reset asserted mid-WAIT SHALL abandon the operation; a late unit_ready after release SHALL be ignored in IDLE.

Verification
REQ-032 Divider req_sel=0, ready 5 cycles after unit_en, result 0x0000_0007 -> unit_en=001 for one cycle, stall high 7 cycles, resp_data=7, error=0, held until ack.
REQ-033 FPU req_sel=2, ready never asserted, TIMEOUT=8 -> unit_en=100 once, resp_valid with error=1, data=0 after exactly 8 WAIT cycles.
REQ-034 req_sel=3 -> no unit_en pulse, DONE next cycle, error=1; ack -> IDLE.
REQ-035 clmul req_sel=1, clear pulsed in WAIT with unit_ready=010 in the same cycle -> IDLE, resp_valid never asserted.
REQ-036 rst asserted asynchronously between edges during WAIT -> busy, stall and unit_en go 0 at once; after release, stray unit_ready=001 -> no response.
REQ-037 Response held 3 cycles without ack, unit_result changing -> resp_data unchanged until ack.

Source files
------------

// File: rtl/mcycle_scheduler_if.sv
// Execute-stage / functional-unit bundle for the multi-cycle scheduler.
//   master : execute stage plus unit models (drives requests, unit_ready/unit_result, ack)
//   slave  : the scheduler (drives unit_en, response, stall, busy)
// unit_result packs unit i into bits [i*XLEN +: XLEN].
interface mcycle_scheduler_if #(
    parameter int unsigned XLEN = 32
);
    logic                req_valid;
    logic [1:0]          req_sel;
    logic                clear;
    logic [2:0]          unit_en;
    logic [2:0]          unit_ready;
    logic [3*XLEN-1:0]   unit_result;
    logic                resp_valid;
    logic [XLEN-1:0]     resp_data;
    logic                resp_error;
    logic                resp_ack;
    logic                stall;
    logic                busy;

    modport master (
        output req_valid, req_sel, clear, unit_ready, unit_result, resp_ack,
        input  unit_en, resp_valid, resp_data, resp_error, stall, busy
    );

    modport slave (
        input  req_valid, req_sel, clear, unit_ready, unit_result, resp_ack,
        output unit_en, resp_valid, resp_data, resp_error, stall, busy
    );
endinterface

// File: rtl/mcycle_scheduler.sv
// Multi-cycle operation scheduler: accepts one request from the execute stage,
// pulses the start of the selected unit (divider, clmul, FPU), waits for its
// ready with a timeout, and holds the result until acknowledged.
// Ports:
//   clk  - sole clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - mcycle_scheduler_if.slave (request, unit start/ready/result,
//          response, stall, busy)
module mcycle_scheduler #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    mcycle_scheduler_if.slave bus
);
    localparam int unsigned CntW = $clog2(TIMEOUT);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

    state_e            state_q, state_d;
    logic [1:0]        sel_q, sel_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0]   data_q, data_d;
    logic              err_q, err_d;

    logic [2:0]        sel_onehot;
    logic              sel_ready;
    logic [XLEN-1:0]   sel_result;

    // Only the latched unit is observed; the reserved selector maps to nothing.
    always_comb begin
        sel_onehot = 3'b000;
        sel_result = '0;
        case (sel_q)
            2'd0: begin
                sel_onehot = 3'b001;
                sel_result = bus.unit_result[0 +: XLEN];
            end
            2'd1: begin
                sel_onehot = 3'b010;
                sel_result = bus.unit_result[XLEN +: XLEN];
            end
            2'd2: begin
                sel_onehot = 3'b100;
                sel_result = bus.unit_result[2*XLEN +: XLEN];
            end
            default: begin
            end
        endcase
        sel_ready = |(bus.unit_ready & sel_onehot);
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        err_d   = err_q;

        case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    sel_d = bus.req_sel;
                    if (bus.req_sel == 2'd3) begin
                        state_d = StDone;
                        err_d   = 1'b1;
                        data_d  = '0;
                    end else begin
                        state_d = StIssue;
                    end
                end
            end
            StIssue: begin
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                // Ready wins over a coincident timeout.
                if (sel_ready) begin
                    data_d  = sel_result;
                    err_d   = 1'b0;
                    state_d = StDone;
                end else if (cnt_q == CntLast) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDone: begin
                if (bus.resp_ack) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Flush overrides everything and drops any captured result.
        if (bus.clear) begin
            state_d = StIdle;
            cnt_d   = '0;
            data_d  = '0;
            err_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            sel_q   <= 2'd0;
            cnt_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    // Outputs are gated by rst so they drop the moment reset asserts, even
    // when the request inputs are still active.
    always_comb begin
        bus.unit_en    = 3'b000;
        bus.resp_valid = 1'b0;
        bus.stall      = 1'b0;
        bus.busy       = 1'b0;
        if (!rst) begin
            if (state_q == StIssue && !bus.clear) begin
                bus.unit_en = sel_onehot;
            end
            bus.resp_valid = (state_q == StDone);
            bus.stall      = (state_q == StIdle && bus.req_valid && !bus.clear) ||
                             (state_q == StIssue) || (state_q == StWait);
            bus.busy       = (state_q != StIdle);
        end
        bus.resp_data  = data_q;
        bus.resp_error = err_q;
    end
endmodule

// File: tb/tb_mcycle_scheduler.sv
module tb_mcycle_scheduler;
    localparam int unsigned XLEN    = 32;
    localparam int unsigned TIMEOUT = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mcycle_scheduler_if #(.XLEN(XLEN)) bus ();

    mcycle_scheduler #(
        .XLEN    (XLEN),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // delay: cycles from the unit_en cycle to the ready cycle (0 = never)
    typedef struct {
        logic [1:0]  sel;
        int          delay;
        logic [31:0] result;
        logic        ack_early;
        logic [2:0]  exp_en;
        logic        exp_err;
        logic [31:0] exp_data;
        int          exp_stall;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } resp_t;

    vec_t  vecs[7];
    resp_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [95:0] rnd96();
        return {$urandom(), $urandom(), $urandom()};
    endfunction

    // Every unit other than the selected one reports ready, to catch wrong-unit sampling.
    function automatic logic [2:0] noise(input logic [1:0] sel);
        logic [2:0] m;
        m = 3'b111;
        if (sel != 2'd3) m[int'(sel)] = 1'b0;
        return m;
    endfunction

    task automatic drive_idle();
        bus.req_valid   = 1'b0;
        bus.req_sel     = 2'd0;
        bus.clear       = 1'b0;
        bus.resp_ack    = 1'b0;
        bus.unit_ready  = 3'b000;
        bus.unit_result = '0;
    endtask

    task automatic run_vec(input int idx);
        vec_t       v;
        resp_t      e;
        int         cyc, en_cyc, en_cnt, stall_cnt, valid_cyc;
        logic [2:0] en_seen;
        v = vecs[idx];
        tick();
        bus.req_valid   = 1'b1;
        bus.req_sel     = v.sel;
        bus.resp_ack    = v.ack_early;
        bus.unit_ready  = noise(v.sel);
        bus.unit_result = rnd96();
        exp_q.push_back('{data: v.exp_data, err: v.exp_err});
        cyc = 0; en_cyc = -1; en_cnt = 0; stall_cnt = 0; valid_cyc = -1; en_seen = 3'b000;
        while (valid_cyc < 0 && cyc < 40) begin
            @(negedge clk);
            if (bus.stall) stall_cnt++;
            if (bus.unit_en != 3'b000) begin
                en_cnt++;
                en_seen |= bus.unit_en;
                en_cyc = cyc;
            end
            if (bus.resp_valid) begin
                valid_cyc = cyc;
            end else begin
                tick();
                cyc++;
                bus.req_valid   = 1'b0;
                bus.resp_ack    = v.ack_early && (cyc < v.exp_stall);
                bus.unit_result = rnd96();
                bus.unit_ready  = noise(v.sel);
                if (en_cyc >= 0 && v.delay > 0 && cyc == en_cyc + v.delay && v.sel != 2'd3) begin
                    bus.unit_ready[int'(v.sel)] = 1'b1;
                    bus.unit_result[int'(v.sel)*XLEN +: XLEN] = v.result;
                end
            end
        end
        check($sformatf("v%0d_resp_seen", idx), valid_cyc >= 0, 1);
        e = exp_q.pop_front();
        check($sformatf("v%0d_unit_en", idx), en_seen, v.exp_en);
        check($sformatf("v%0d_en_pulses", idx), en_cnt, (v.exp_en != 3'b000) ? 1 : 0);
        check($sformatf("v%0d_stall_cycles", idx), stall_cnt, v.exp_stall);
        check($sformatf("v%0d_latency", idx), valid_cyc, v.exp_stall);
        check($sformatf("v%0d_data", idx), bus.resp_data, e.data);
        check($sformatf("v%0d_error", idx), bus.resp_error, e.err);
        // Hold without ack while unit outputs churn.
        for (int h = 0; h < 3; h++) begin
            tick();
            bus.resp_ack    = 1'b0;
            bus.unit_result = rnd96();
            bus.unit_ready  = 3'b111;
            @(negedge clk);
            check($sformatf("v%0d_hold%0d_valid", idx, h), bus.resp_valid, 1);
            check($sformatf("v%0d_hold%0d_data", idx, h), bus.resp_data, e.data);
            check($sformatf("v%0d_hold%0d_error", idx, h), bus.resp_error, e.err);
        end
        tick();
        bus.resp_ack   = 1'b1;
        bus.unit_ready = 3'b000;
        @(negedge clk);
        check($sformatf("v%0d_valid_at_ack", idx), bus.resp_valid, 1);
        tick();
        bus.resp_ack = 1'b0;
        @(negedge clk);
        check($sformatf("v%0d_valid_after_ack", idx), bus.resp_valid, 0);
        check($sformatf("v%0d_busy_after_ack", idx), bus.busy, 0);
        if (valid_cyc < 0) begin
            tick();
            bus.clear = 1'b1;
            tick();
            bus.clear = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int vcnt;
        //            sel   dly result        ack  en      err   data          stall
        vecs[0] = '{2'd0, 5, 32'h0000_0007, 1'b0, 3'b001, 1'b0, 32'h0000_0007, 7};
        vecs[1] = '{2'd1, 1, 32'hDEAD_BEEF, 1'b0, 3'b010, 1'b0, 32'hDEAD_BEEF, 3};
        vecs[2] = '{2'd2, 0, 32'h1111_2222, 1'b0, 3'b100, 1'b1, 32'h0000_0000, 10};
        vecs[3] = '{2'd3, 0, 32'h0000_0000, 1'b0, 3'b000, 1'b1, 32'h0000_0000, 1};
        vecs[4] = '{2'd2, 8, 32'h1234_5678, 1'b0, 3'b100, 1'b0, 32'h1234_5678, 10};
        vecs[5] = '{2'd0, 9, 32'h0000_0055, 1'b0, 3'b001, 1'b1, 32'h0000_0000, 10};
        vecs[6] = '{2'd1, 7, 32'hA5A5_0F0F, 1'b1, 3'b010, 1'b0, 32'hA5A5_0F0F, 9};

        // Reset: outputs low even with a request pending.
        drive_idle();
        rst           = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_sel   = 2'd1;
        #3;
        check("rst_stall", bus.stall, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_resp_valid", bus.resp_valid, 0);
        check("rst_unit_en", bus.unit_en, 0);
        #9;
        bus.req_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_busy", bus.busy, 0);
        check("post_rst_data", bus.resp_data, 0);
        check("post_rst_error", bus.resp_error, 0);

        vcnt = 7;
        for (int i = 0; i < vcnt; i++) run_vec(i);

        // Request with clear in IDLE is not accepted.
        tick();
        bus.req_valid = 1'b1; bus.req_sel = 2'd0; bus.clear = 1'b1;
        @(negedge clk);
        check("idle_clear_stall", bus.stall, 0);
        tick();
        bus.req_valid = 1'b0; bus.clear = 1'b0;
        @(negedge clk);
        check("idle_clear_busy", bus.busy, 0);

        // Clear during ISSUE suppresses the start pulse.
        tick();
        bus.req_valid = 1'b1; bus.req_sel = 2'd0;
        tick();
        bus.req_valid = 1'b0; bus.clear = 1'b1;
        @(negedge clk);
        check("issue_clear_unit_en", bus.unit_en, 0);
        tick();
        bus.clear = 1'b0;
        @(negedge clk);
        check("issue_clear_busy", bus.busy, 0);

        // Clmul: clear in WAIT coinciding with its ready.
        tick();
        bus.req_valid = 1'b1; bus.req_sel = 2'd1;
        tick();
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("clmul_unit_en", bus.unit_en, 3'b010);
        tick();
        bus.clear = 1'b1; bus.unit_ready = 3'b010;
        bus.unit_result[XLEN +: XLEN] = 32'hCAFE_F00D;
        tick();
        bus.clear = 1'b0;
        @(negedge clk);
        check("wait_clear_busy", bus.busy, 0);
        begin
            int vhits;
            vhits = 0;
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                if (bus.resp_valid) vhits++;
            end
            check("wait_clear_no_resp", vhits, 0);
        end
        bus.unit_ready = 3'b000;

        // Clear in DONE beats a simultaneous ack and drops the error.
        tick();
        bus.req_valid = 1'b1; bus.req_sel = 2'd3;
        tick();
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("done_reserved_error", bus.resp_error, 1);
        tick();
        bus.clear = 1'b1; bus.resp_ack = 1'b1;
        tick();
        bus.clear = 1'b0; bus.resp_ack = 1'b0;
        @(negedge clk);
        check("done_clear_valid", bus.resp_valid, 0);
        check("done_clear_error", bus.resp_error, 0);
        check("done_clear_busy", bus.busy, 0);

        // Asynchronous reset mid-WAIT, then a stray ready.
        tick();
        bus.req_valid = 1'b1; bus.req_sel = 2'd0;
        tick();
        bus.req_valid = 1'b0;
        tick();
        @(negedge clk);
        check("pre_arst_busy", bus.busy, 1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_busy", bus.busy, 0);
        check("arst_stall", bus.stall, 0);
        check("arst_unit_en", bus.unit_en, 0);
        check("arst_resp_valid", bus.resp_valid, 0);
        tick();
        rst = 1'b0;
        bus.unit_ready = 3'b001;
        bus.unit_result[0 +: XLEN] = 32'h0000_0099;
        begin
            int hits;
            hits = 0;
            for (int k = 0; k < 6; k++) begin
                @(negedge clk);
                if (bus.resp_valid || bus.busy) hits++;
            end
            check("stray_ready_ignored", hits, 0);
        end
        bus.unit_ready = 3'b000;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
